// File: rtl/cmd_tag_credit_issue.sv
// Command issue stage toward PSL: allocates the lowest free tag and spends a credit
// per accepted request, then retires tags and recovers credits from PSL responses.
package cmd_tag_credit_issue_pkg;
  localparam logic [2:0] ABT_STRICT = 3'd0;

  typedef struct packed {
    logic [7:0] room;
  } command_in_t;

  typedef struct packed {
    logic        valid;
    logic [7:0]  tag;
    logic        tag_parity;
    logic [12:0] command;
    logic        command_parity;
    logic [2:0]  abt;
    logic [63:0] address;
    logic        address_parity;
    logic [15:0] context_handle;
    logic [11:0] size;
  } command_out_t;

  typedef struct packed {
    logic               valid;
    logic [7:0]         tag;
    logic               tag_parity;
    logic [7:0]         response;
    logic signed [8:0]  credits;
  } response_in_t;
endpackage

module cmd_tag_credit_issue
  import cmd_tag_credit_issue_pkg::*;
#(
  parameter int NUM_TAGS     = 32,
  parameter int CREDIT_WIDTH = 9
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enabled,
  input  command_in_t   command_in,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [12:0]   req_command,
  input  logic [63:0]   req_address,
  input  logic [11:0]   req_size,
  input  logic [15:0]   req_context,
  output command_out_t  command_out,
  input  response_in_t  response_in,
  output logic          rsp_valid,
  output logic [7:0]    rsp_tag,
  output logic [7:0]    rsp_response,
  output logic [8:0]    outstanding,
  output logic          idle,
  output logic [1:0]    error
);
  localparam int SW = CREDIT_WIDTH + 2;

  logic                           enabled_q;
  logic signed [CREDIT_WIDTH-1:0] credits;
  logic [NUM_TAGS-1:0]            tag_alloc;
  logic [NUM_TAGS-1:0]            free_onehot;
  logic [NUM_TAGS-1:0]            rsp_hit;
  logic                           any_free;
  logic [7:0]                     free_tag;
  logic                           tag_known;
  logic                           parity_ok;
  logic                           resp_ok;
  logic                           accept;
  logic                           credit_load;
  logic signed [SW-1:0]           room_ext;
  logic signed [SW-1:0]           resp_ext;
  logic signed [SW-1:0]           credit_base;
  logic signed [SW-1:0]           credit_sum;
  logic signed [SW-1:0]           credit_sat;
  logic [8:0]                     outstanding_next;

  // Handshake: a request transfers on any cycle where req_valid and req_ready are
  // both high; req_ready never depends on req_valid.
  always_comb begin
    any_free    = 1'b0;
    free_tag    = '0;
    free_onehot = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!tag_alloc[i]) begin
        any_free       = 1'b1;
        free_tag       = 8'(i);
        free_onehot    = '0;
        free_onehot[i] = 1'b1;
      end
    end
    // Tags outside the pool never match, so range and allocation share one check.
    rsp_hit = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (response_in.tag == 8'(i)) rsp_hit[i] = 1'b1;
    end
    tag_known = |(rsp_hit & tag_alloc);
    parity_ok = (response_in.tag_parity == ~^response_in.tag);
    resp_ok   = response_in.valid & tag_known & parity_ok;

    req_ready   = enabled & ~credits[CREDIT_WIDTH-1] & (credits != '0) & any_free & ~reset;
    accept      = req_valid & req_ready;
    credit_load = enabled & ~enabled_q;

    room_ext    = $signed({{(SW-8){1'b0}}, command_in.room});
    resp_ext    = resp_ok ? $signed({{(SW-9){response_in.credits[8]}}, response_in.credits}) : '0;
    credit_base = credit_load ? room_ext : $signed({{2{credits[CREDIT_WIDTH-1]}}, credits});
    credit_sum  = credit_base - $signed({{(SW-1){1'b0}}, accept}) + resp_ext;
    if (credit_sum[SW-1])          credit_sat = '0;
    else if (credit_sum > room_ext) credit_sat = room_ext;
    else                            credit_sat = credit_sum;

    outstanding_next = outstanding + 9'(accept) - 9'(resp_ok);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      enabled_q    <= 1'b0;
      credits      <= '0;
      tag_alloc    <= '0;
      outstanding  <= '0;
      command_out  <= '0;
      rsp_valid    <= 1'b0;
      rsp_tag      <= '0;
      rsp_response <= '0;
      idle         <= 1'b0;
      error        <= '0;
    end else begin
      enabled_q <= enabled;
      if (enabled) credits <= credit_sat[CREDIT_WIDTH-1:0];
      tag_alloc   <= (tag_alloc | (accept ? free_onehot : '0)) & ~(resp_ok ? rsp_hit : '0);
      outstanding <= outstanding_next;
      idle        <= (outstanding_next == '0) & ~accept;

      command_out.valid <= accept;
      command_out.abt   <= ABT_STRICT;
      if (accept) begin
        command_out.tag            <= free_tag;
        command_out.tag_parity     <= ~^free_tag;
        command_out.command        <= req_command;
        command_out.command_parity <= ~^req_command;
        command_out.address        <= req_address;
        command_out.address_parity <= ~^req_address;
        command_out.context_handle <= req_context;
        command_out.size           <= req_size;
      end

      rsp_valid <= resp_ok;
      if (resp_ok) begin
        rsp_tag      <= response_in.tag;
        rsp_response <= response_in.response;
      end

      if (response_in.valid & ~parity_ok) error[0] <= 1'b1;
      if (response_in.valid & ~tag_known) error[1] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cmd_tag_credit_issue.sv
// Directed bench for cmd_tag_credit_issue: a 32-tag instance and a 2-tag instance
// share stimulus; each is held in reset while the other is being exercised.
module tb_cmd_tag_credit_issue;
  import cmd_tag_credit_issue_pkg::*;

  logic          clk = 1'b0;
  logic          rst_a, rst_b, enabled;
  command_in_t   cin;
  logic          req_valid;
  logic [12:0]   req_command;
  logic [63:0]   req_address;
  logic [11:0]   req_size;
  logic [15:0]   req_context;
  response_in_t  rin;

  logic          a_ready, b_ready, a_rsp_valid, b_rsp_valid, a_idle, b_idle;
  command_out_t  a_cmd, b_cmd;
  logic [7:0]    a_rsp_tag, b_rsp_tag, a_rsp_code, b_rsp_code;
  logic [8:0]    a_out, b_out;
  logic [1:0]    a_err, b_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cmd_tag_credit_issue dut (
    .clock(clk), .reset(rst_a), .enabled(enabled), .command_in(cin),
    .req_valid(req_valid), .req_ready(a_ready), .req_command(req_command),
    .req_address(req_address), .req_size(req_size), .req_context(req_context),
    .command_out(a_cmd), .response_in(rin), .rsp_valid(a_rsp_valid),
    .rsp_tag(a_rsp_tag), .rsp_response(a_rsp_code), .outstanding(a_out),
    .idle(a_idle), .error(a_err)
  );

  cmd_tag_credit_issue #(.NUM_TAGS(2)) dut2 (
    .clock(clk), .reset(rst_b), .enabled(enabled), .command_in(cin),
    .req_valid(req_valid), .req_ready(b_ready), .req_command(req_command),
    .req_address(req_address), .req_size(req_size), .req_context(req_context),
    .command_out(b_cmd), .response_in(rin), .rsp_valid(b_rsp_valid),
    .rsp_tag(b_rsp_tag), .rsp_response(b_rsp_code), .outstanding(b_out),
    .idle(b_idle), .error(b_err)
  );

  task automatic check(input string tag, input logic ok);
    checks++;
    assert (ok === 1'b1) else begin
      failures++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [12:0] c, input logic [63:0] a,
                         input logic [11:0] s, input logic [15:0] x);
    req_valid   = 1'b1;
    req_command = c;
    req_address = a;
    req_size    = s;
    req_context = x;
  endtask

  task automatic drive_rsp(input logic [7:0] t, input logic flip,
                           input logic [7:0] code, input logic signed [8:0] cr);
    rin.valid      = 1'b1;
    rin.tag        = t;
    rin.tag_parity = (~^t) ^ flip;
    rin.response   = code;
    rin.credits    = cr;
  endtask

  function automatic command_out_t exp_cmd(input logic [7:0] t);
    command_out_t e;
    e.valid          = 1'b1;
    e.tag            = t;
    e.tag_parity     = ~^t;
    e.command        = req_command;
    e.command_parity = ~^req_command;
    e.abt            = 3'd0;
    e.address        = req_address;
    e.address_parity = ~^req_address;
    e.context_handle = req_context;
    e.size           = req_size;
    return e;
  endfunction

  command_out_t exp_c;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; enabled = 1'b0; cin.room = 8'd4;
    req_valid = 1'b0; req_command = '0; req_address = '0; req_size = '0; req_context = '0;
    rin = '0;
    tick(); tick();
    check("rst_cmd", a_cmd === '0);
    check("rst_ready", a_ready === 1'b0);
    check("rst_out", a_out === 9'd0);
    check("rst_err", a_err === 2'd0);
    check("rst_rsp", a_rsp_valid === 1'b0);
    check("rst_idle", a_idle === 1'b0);
    rst_a = 1'b0;
    tick();
    check("idle_after_rst", a_idle === 1'b1);

    enabled = 1'b1;
    check("t1_ready_load_cycle", a_ready === 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      set_req(13'h100 + 13'(i), 64'hA000_0000_0000_0000 + 64'(i * 128), 12'(64 + i), 16'(16'h1000 + i));
      check("t1_ready", a_ready === 1'b1);
      exp_c = exp_cmd(8'(i));
      tick();
      check("t1_issue", a_cmd === exp_c);
    end
    set_req(13'h1AB, 64'hDEAD_BEEF_0000_1000, 12'd128, 16'h5A5A);
    check("t1_stall_ready", a_ready === 1'b0);
    tick();
    check("t1_stall_valid", a_cmd.valid === 1'b0);
    check("t1_out", a_out === 9'd4);
    check("t1_idle", a_idle === 1'b0);

    drive_rsp(8'd2, 1'b0, 8'h00, 9'sd1);
    check("t2_ready_same_cycle", a_ready === 1'b0);
    tick();
    rin.valid = 1'b0;
    check("t2_rsp_valid", a_rsp_valid === 1'b1);
    check("t2_rsp_tag", a_rsp_tag === 8'd2);
    check("t2_rsp_code", a_rsp_code === 8'h00);
    check("t2_out", a_out === 9'd3);
    check("t2_ready", a_ready === 1'b1);
    exp_c = exp_cmd(8'd2);
    tick();
    check("t2_issue", a_cmd === exp_c);
    check("t2_rsp_pulse", a_rsp_valid === 1'b0);
    check("t2_out_after", a_out === 9'd4);
    check("t2_ready_after", a_ready === 1'b0);

    req_valid = 1'b0;
    drive_rsp(8'd0, 1'b0, 8'h01, 9'sd1);
    tick();
    rin.valid = 1'b0;
    check("t3_rsp_tag0", a_rsp_tag === 8'd0);
    check("t3_out_pre", a_out === 9'd3);
    set_req(13'h0C0, 64'h0000_0000_1234_5678, 12'd32, 16'hBEEF);
    drive_rsp(8'd3, 1'b0, 8'h00, 9'sd1);
    check("t3_ready", a_ready === 1'b1);
    exp_c = exp_cmd(8'd0);
    tick();
    rin.valid = 1'b0;
    req_valid = 1'b0;
    check("t3_issue", a_cmd === exp_c);
    check("t3_out_same", a_out === 9'd3);
    check("t3_rsp_tag3", a_rsp_tag === 8'd3);
    check("t3_credit_left", a_ready === 1'b1);
    set_req(13'h0C1, 64'hFFFF_0000_FFFF_0001, 12'd8, 16'h0001);
    exp_c = exp_cmd(8'd3);
    tick();
    req_valid = 1'b0;
    check("t3_issue_last", a_cmd === exp_c);
    check("t3_credits_spent", a_ready === 1'b0);

    drive_rsp(8'd7, 1'b0, 8'h00, 9'sd1);
    tick();
    check("t4_err_tag", a_err === 2'b10);
    check("t4_rsp_drop1", a_rsp_valid === 1'b0);
    drive_rsp(8'd1, 1'b1, 8'h00, 9'sd1);
    tick();
    rin.valid = 1'b0;
    check("t4_err_both", a_err === 2'b11);
    check("t4_rsp_drop2", a_rsp_valid === 1'b0);
    check("t4_out", a_out === 9'd4);
    check("t4_no_credit", a_ready === 1'b0);

    drive_rsp(8'd1, 1'b0, 8'h01, 9'sd0);
    tick();
    rin.valid = 1'b0;
    check("t6_out_pre", a_out === 9'd3);
    check("t6_rsp_code", a_rsp_code === 8'h01);
    rst_a = 1'b1; enabled = 1'b0;
    tick();
    check("t6_cmd", a_cmd === '0);
    check("t6_rsp_valid", a_rsp_valid === 1'b0);
    check("t6_rsp_tag", a_rsp_tag === 8'd0);
    check("t6_out", a_out === 9'd0);
    check("t6_err", a_err === 2'd0);
    check("t6_ready", a_ready === 1'b0);
    check("t6_idle", a_idle === 1'b0);
    rst_a = 1'b0; cin.room = 8'd2;
    tick();
    enabled = 1'b1;
    tick();
    set_req(13'h0AA, 64'h0000_0000_0000_0040, 12'd64, 16'h0002);
    check("t6_ready_reload", a_ready === 1'b1);
    exp_c = exp_cmd(8'd0);
    tick();
    check("t6_issue0", a_cmd === exp_c);
    exp_c = exp_cmd(8'd1);
    tick();
    req_valid = 1'b0;
    check("t6_issue1", a_cmd === exp_c);
    check("t6_credits_two", a_ready === 1'b0);

    rst_a = 1'b1; rst_b = 1'b0; enabled = 1'b0; cin.room = 8'd8;
    tick();
    enabled = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      set_req(13'h1F0 + 13'(i * 7), 64'h0123_4567_89AB_CDEF ^ 64'(i * 3), 12'd16, 16'h00F0);
      check("t5_ready", b_ready === 1'b1);
      exp_c = exp_cmd(8'(i));
      tick();
      check("t5_issue", b_cmd === exp_c);
      check("t5_tag_par", b_cmd.tag_parity === (~^exp_c.tag));
      check("t5_cmd_par", b_cmd.command_parity === (~^exp_c.command));
      check("t5_addr_par", b_cmd.address_parity === (~^exp_c.address));
    end
    set_req(13'h0FF, 64'h7000_0000_0000_0003, 12'd4, 16'h0003);
    check("t5_exhausted", b_ready === 1'b0);
    tick();
    check("t5_no_issue", b_cmd.valid === 1'b0);
    check("t5_out", b_out === 9'd2);
    drive_rsp(8'd1, 1'b0, 8'h03, 9'sd0);
    check("t5_not_same_cycle", b_ready === 1'b0);
    tick();
    rin.valid = 1'b0;
    check("t5_rsp_tag", b_rsp_tag === 8'd1);
    check("t5_ready_after", b_ready === 1'b1);
    exp_c = exp_cmd(8'd1);
    tick();
    req_valid = 1'b0;
    check("t5_issue_retired", b_cmd === exp_c);
    check("t5_tag_par3", b_cmd.tag_parity === 1'b0);
    check("t5_cmd_par3", b_cmd.command_parity === (~^13'h0FF));
    check("t5_addr_par3", b_cmd.address_parity === 1'b0);
    check("t5_out_final", b_out === 9'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
